// File: rtl/extram_arbiter.sv
// Single-port controller for a 512Kx8 asynchronous SRAM shared by the VGA scan-out
// engine (fixed-latency reads) and an 8-bit Wishbone CPU port served in the gaps.
module extram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [18:0] ADR_I,
  input  logic [7:0]  DAT_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [7:0]  DAT_O,
  input  logic        I_vga_req,
  input  logic [18:0] I_vga_adr,
  output logic [7:0]  O_vga_dat,
  output logic        O_vga_miss,
  output logic [18:0] O_sram_adr,
  output logic [7:0]  O_sram_dat,
  output logic        O_sram_dat_oe,
  input  logic [7:0]  I_sram_dat,
  output logic        O_sram_ce_n,
  output logic        O_sram_oe_n,
  output logic        O_sram_we_n
);
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, VREAD, CREAD, CWRITE, CREC} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vpend_q, vpend_d;
  logic [18:0]   vadr_q, vadr_d;
  logic [18:0]   sadr_q, sadr_d;
  logic [7:0]    sdat_q, sdat_d;
  logic [7:0]    cdat_q, cdat_d;
  logic [7:0]    vdat_q, vdat_d;
  logic          ack_q, ack_d;
  logic          miss_q, miss_d;
  logic          last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vpend_q <= 1'b0;
      vadr_q  <= '0;
      sadr_q  <= '0;
      sdat_q  <= '0;
      cdat_q  <= '0;
      vdat_q  <= '0;
      ack_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vpend_q <= vpend_d;
      vadr_q  <= vadr_d;
      sadr_q  <= sadr_d;
      sdat_q  <= sdat_d;
      cdat_q  <= cdat_d;
      vdat_q  <= vdat_d;
      ack_q   <= ack_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vpend_d = vpend_q;
    vadr_d  = vadr_q;
    sadr_d  = sadr_q;
    sdat_d  = sdat_q;
    cdat_d  = cdat_q;
    vdat_d  = vdat_q;
    ack_d   = 1'b0;
    miss_d  = 1'b0;

    // vpend means "latched, access not yet launched": a request landing on it is a miss.
    if (I_vga_req) begin
      vadr_d  = I_vga_adr;
      vpend_d = 1'b1;
      miss_d  = vpend_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (vpend_q || I_vga_req) begin
          // The read address is captured at launch, so later requests only touch vadr.
          state_d = VREAD;
          sadr_d  = I_vga_req ? I_vga_adr : vadr_q;
          vpend_d = 1'b0;
        end else if (STB_I && !ack_q) begin
          state_d = WE_I ? CWRITE : CREAD;
          sadr_d  = ADR_I;
          sdat_d  = DAT_I;
        end
      end
      VREAD: begin
        if (last) begin
          vdat_d  = I_sram_dat;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CREAD: begin
        if (last) begin
          cdat_d  = I_sram_dat;
          ack_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CWRITE: begin
        if (last) begin
          state_d = CREC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CREC: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM strobes decode straight from the state so reset drops them at the same edge.
  always_comb begin
    O_sram_ce_n   = (state_q == IDLE);
    O_sram_oe_n   = !((state_q == VREAD) || (state_q == CREAD));
    O_sram_we_n   = (state_q != CWRITE);
    O_sram_dat_oe = (state_q == CWRITE) || (state_q == CREC);
  end

  assign O_sram_adr = sadr_q;
  assign O_sram_dat = sdat_q;
  assign ACK_O      = ack_q;
  assign DAT_O      = cdat_q;
  assign O_vga_dat  = vdat_q;
  assign O_vga_miss = miss_q;

endmodule

// File: tb/tb_extram_arbiter.sv
// Bench for extram_arbiter: one instance with ACCESS_CYCLES=1 (sel 0) and one with
// ACCESS_CYCLES=2 (sel 1), each on its own SRAM model; expectations go through queues.
module tb_extram_arbiter;
  localparam int NSRAM = 524288;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, stb, we, vreq;
  logic [18:0] adr, vadr;
  logic [7:0]  wdat;
  int          sel;

  logic [1:0]       stb_g, vreq_g, ack, miss, sdoe, ce_n, oe_n, we_n;
  logic [1:0][7:0]  dato, vdat, sdo, sdi;
  logic [1:0][18:0] sadr;

  assign stb_g[0]  = stb  && (sel == 0);
  assign stb_g[1]  = stb  && (sel == 1);
  assign vreq_g[0] = vreq && (sel == 0);
  assign vreq_g[1] = vreq && (sel == 1);

  extram_arbiter #(.ACCESS_CYCLES(1)) u_a1 (
    .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(wdat), .STB_I(stb_g[0]), .WE_I(we),
    .ACK_O(ack[0]), .DAT_O(dato[0]), .I_vga_req(vreq_g[0]), .I_vga_adr(vadr),
    .O_vga_dat(vdat[0]), .O_vga_miss(miss[0]), .O_sram_adr(sadr[0]), .O_sram_dat(sdo[0]),
    .O_sram_dat_oe(sdoe[0]), .I_sram_dat(sdi[0]), .O_sram_ce_n(ce_n[0]),
    .O_sram_oe_n(oe_n[0]), .O_sram_we_n(we_n[0]));

  extram_arbiter #(.ACCESS_CYCLES(2)) u_a2 (
    .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(wdat), .STB_I(stb_g[1]), .WE_I(we),
    .ACK_O(ack[1]), .DAT_O(dato[1]), .I_vga_req(vreq_g[1]), .I_vga_adr(vadr),
    .O_vga_dat(vdat[1]), .O_vga_miss(miss[1]), .O_sram_adr(sadr[1]), .O_sram_dat(sdo[1]),
    .O_sram_dat_oe(sdoe[1]), .I_sram_dat(sdi[1]), .O_sram_ce_n(ce_n[1]),
    .O_sram_oe_n(oe_n[1]), .O_sram_we_n(we_n[1]));

  // Unwritten SRAM contents follow a fixed pattern, with 0xA5 planted at 0x20000.
  function automatic logic [7:0] pat(logic [18:0] a);
    return (a == 19'h20000) ? 8'hA5 : (a[7:0] ^ a[18:11]);
  endfunction

  logic [7:0] mem [2][NSRAM];
  bit         wrf [2][NSRAM];

  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (!ce_n[d] && !we_n[d]) begin
        mem[d][sadr[d]] <= sdoe[d] ? sdo[d] : 8'h5A;
        wrf[d][sadr[d]] <= 1'b1;
      end

  always_comb
    for (int d = 0; d < 2; d++) begin
      sdi[d] = 8'hEE;
      if (!ce_n[d] && !oe_n[d] && !sdoe[d])
        sdi[d] = wrf[d][sadr[d]] ? mem[d][sadr[d]] : pat(sadr[d]);
    end

  int checks = 0;
  int fails  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int sel; int due; logic [7:0] dat; } vexp_t;
  typedef struct { int sel; int due; bit rd; logic [7:0] dat; } cexp_t;
  vexp_t vq[$];
  cexp_t cq[$];
  vexp_t ve_c;
  cexp_t ce_c;
  logic [7:0] shad [int];

  function automatic logic [7:0] expm(int d, logic [18:0] a);
    int key = d * NSRAM + int'(a);
    return shad.exists(key) ? shad[key] : pat(a);
  endfunction

  int oe_lo[2], we_lo[2], crec_c[2], miss_c[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!oe_n[d]) oe_lo[d]++;
      if (!we_n[d]) we_lo[d]++;
      if (!ce_n[d] && we_n[d] && sdoe[d]) crec_c[d]++;
      if (miss[d]) miss_c[d]++;
    end
    if (!rst) begin
      for (int d = 0; d < 2; d++) chk("oe_we_exclusive", 32'(oe_n[d] | we_n[d]), 32'd1);
      while (vq.size() > 0 && vq[0].due <= cyc) begin
        ve_c = vq.pop_front();
        if (ve_c.due == cyc) chk("vga_dat", 32'(vdat[ve_c.sel]), 32'(ve_c.dat));
        else begin
          checks++; fails++;
          $display("FAIL vga_late cyc=%0d due=%0d", cyc, ve_c.due);
        end
      end
      for (int d = 0; d < 2; d++)
        if (ack[d]) begin
          if (cq.size() == 0 || cq[0].sel != d) begin
            checks++; fails++;
            $display("FAIL cpu_ack_unexpected dut=%0d cyc=%0d", d, cyc);
          end else begin
            ce_c = cq.pop_front();
            chk("cpu_ack_cycle", cyc, ce_c.due);
            if (ce_c.rd) chk("cpu_rd_dat", 32'(dato[d]), 32'(ce_c.dat));
          end
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vga_set(logic [18:0] a, bit push, int lat);
    vadr = a;
    vreq = 1'b1;
    if (push) vq.push_back('{sel, cyc + lat, expm(sel, a)});
  endtask

  task automatic cpu_start(bit w, logic [18:0] a, logic [7:0] d, logic [7:0] e, int lat);
    we = w; adr = a; wdat = d; stb = 1'b1;
    cq.push_back('{sel, cyc + lat, !w, e});
    if (w) shad[sel * NSRAM + int'(a)] = d;
  endtask

  task automatic cpu_finish();
    int k = 0;
    while (cq.size() != 0 && k < 60) begin
      step();
      k++;
    end
    if (cq.size() != 0) begin
      checks++; fails++;
      $display("FAIL cpu_timeout cyc=%0d pending=%0d", cyc, cq.size());
      cq.delete();
    end
    stb = 1'b0;
  endtask

  typedef struct { bit we; logic [18:0] adr; logic [7:0] wd; logic [7:0] exp; int lat1; int lat2; } vec_t;
  vec_t tbl[8];
  logic [18:0] radr[3];
  logic [7:0]  rexp[3];

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int o, w, c, m, ac;
    tbl[0] = '{1'b1, 19'h00123, 8'h3C, 8'h00, 3, 4};
    tbl[1] = '{1'b0, 19'h00123, 8'h00, 8'h3C, 2, 3};
    tbl[2] = '{1'b1, 19'h7FFFF, 8'hFF, 8'h00, 3, 4};
    tbl[3] = '{1'b0, 19'h7FFFF, 8'h00, 8'hFF, 2, 3};
    tbl[4] = '{1'b1, 19'h40000, 8'h00, 8'h00, 3, 4};
    tbl[5] = '{1'b0, 19'h40000, 8'h00, 8'h00, 2, 3};
    tbl[6] = '{1'b0, 19'h00456, 8'h00, 8'h56, 2, 3};
    tbl[7] = '{1'b0, 19'h20000, 8'h00, 8'hA5, 2, 3};
    radr[0] = 19'h00123; rexp[0] = 8'h3C;
    radr[1] = 19'h7FFFF; rexp[1] = 8'hFF;
    radr[2] = 19'h00456; rexp[2] = 8'h56;

    rst = 1'b1; stb = 1'b0; we = 1'b0; vreq = 1'b0; adr = '0; vadr = '0; wdat = '0; sel = 0;
    repeat (2) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce_n", 32'(ce_n[d]), 32'd1);
      chk("rst_oe_n", 32'(oe_n[d]), 32'd1);
      chk("rst_we_n", 32'(we_n[d]), 32'd1);
      chk("rst_dat_oe", 32'(sdoe[d]), 32'd0);
      chk("rst_sram_adr", 32'(sadr[d]), 32'd0);
      chk("rst_sram_dat", 32'(sdo[d]), 32'd0);
      chk("rst_ack", 32'(ack[d]), 32'd0);
      chk("rst_dat_o", 32'(dato[d]), 32'd0);
      chk("rst_vga_dat", 32'(vdat[d]), 32'd0);
      chk("rst_vga_miss", 32'(miss[d]), 32'd0);
    end
    rst = 1'b0;
    step();

    // Single VGA read, ACCESS_CYCLES=1: data two cycles after the request.
    sel = 0;
    o = oe_lo[0];
    vga_set(19'h20000, 1'b1, 2);
    step();
    vreq = 1'b0;
    chk("vga_not_early", 32'(vdat[0]), 32'd0);
    repeat (2) step();
    chk("vga_oe_cycles", oe_lo[0] - o, 1);

    // CPU vectors on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      ac = s + 1;
      for (int i = 0; i < 8; i++) begin
        o = oe_lo[s]; w = we_lo[s]; c = crec_c[s];
        cpu_start(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].exp, (s == 0) ? tbl[i].lat1 : tbl[i].lat2);
        cpu_finish();
        if (tbl[i].we) begin
          chk("wr_we_cycles", we_lo[s] - w, ac);
          chk("wr_crec_cycles", crec_c[s] - c, 1);
          chk("wr_no_oe", oe_lo[s] - o, 0);
        end else begin
          chk("rd_oe_cycles", oe_lo[s] - o, ac);
          chk("rd_no_we", we_lo[s] - w, 0);
        end
      end
    end

    // Write strobe and VGA request together: VGA first, then the write.
    sel = 1;
    cpu_start(1'b1, 19'h00200, 8'h77, 8'h00, 7);
    vga_set(19'h12345, 1'b1, 3);
    step();
    vreq = 1'b0;
    cpu_finish();
    cpu_start(1'b0, 19'h00200, 8'h00, 8'h77, 3);
    cpu_finish();

    // Two VGA requests queued behind a write: one miss, second address wins.
    m = miss_c[1];
    cpu_start(1'b1, 19'h00500, 8'h11, 8'h00, 4);
    step();
    vga_set(19'h00777, 1'b0, 0);
    step();
    vreq = 1'b0;
    step();
    vga_set(19'h00888, 1'b1, 4);
    step();
    vreq = 1'b0;
    cpu_finish();
    repeat (4) step();
    chk("vga_miss_once", miss_c[1] - m, 1);

    // VGA stream every 2 cycles with a held CPU read that fits only the gap.
    sel = 0;
    m = miss_c[0];
    for (int b = 0; b < 3; b++) begin
      cpu_start(1'b0, radr[b], 8'h00, rexp[b], 10);
      for (int i = 0; i < 4; i++) begin
        vga_set(19'h00100 + 19'(b * 12 + i * 3), 1'b1, 2);
        step();
        vreq = 1'b0;
        step();
      end
      repeat (2) step();
    end
    step();
    stb = 1'b0;
    cpu_finish();
    repeat (3) step();
    chk("stream_no_miss", miss_c[0] - m, 0);

    // Reset in the middle of a write drops the access and the pending VGA read.
    sel = 1;
    we = 1'b1; adr = 19'h00600; wdat = 8'h99; stb = 1'b1;
    step();
    chk("cw_we_low", 32'(we_n[1]), 32'd0);
    vga_set(19'h00700, 1'b0, 0);
    step();
    vreq = 1'b0; stb = 1'b0; rst = 1'b1;
    o = oe_lo[1];
    step();
    chk("abort_we_n", 32'(we_n[1]), 32'd1);
    chk("abort_dat_oe", 32'(sdoe[1]), 32'd0);
    chk("abort_ce_n", 32'(ce_n[1]), 32'd1);
    rst = 1'b0;
    repeat (6) step();
    chk("abort_no_vread", oe_lo[1] - o, 0);

    chk("vq_drained", vq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
